// File: rtl/branch_resolve_if.sv
// Request/resolution bus of the branch resolve unit.
// The master side issues requests and consumes resolutions; the slave side is the unit.
interface branch_resolve_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_branch;
    logic [2:0]      in_comp_code;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_branch, in_comp_code, in_rs1, in_rs2,
               in_pc, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict,
               out_redirect_pc, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_branch, in_comp_code, in_rs1, in_rs2,
               in_pc, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict,
               out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates the comparison, computes the next PC,
// checks the prediction and returns the result through a 2-entry skid buffer.
// Optional statistics counters: define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] redirect_pc;
    } res_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Zero-width counters are meaningless; reject them at elaboration.
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e state_q, state_d;
    res_t   head_q, head_d;
    res_t   tail_q, tail_d;
    res_t   new_c;
    logic   cond_c;
    logic   reserved_c;
    logic   in_ready_c;
    logic   accept_c;
    logic   pop_c;

    // Evaluate the incoming request in its accept cycle.
    always_comb begin
        cond_c = 1'b0;
        case (bus.in_comp_code)
            3'd0:    cond_c = (bus.in_rs1 == bus.in_rs2);
            3'd1:    cond_c = (bus.in_rs1 != bus.in_rs2);
            3'd2:    cond_c = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            3'd3:    cond_c = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            3'd4:    cond_c = (bus.in_rs1 <  bus.in_rs2);
            3'd5:    cond_c = (bus.in_rs1 >= bus.in_rs2);
            default: cond_c = 1'b0;
        endcase
        reserved_c        = (bus.in_comp_code > 3'd5);
        new_c.taken       = bus.in_branch && cond_c;
        new_c.illegal     = bus.in_branch && reserved_c;
        new_c.mispredict  = bus.in_branch && (new_c.taken ^ bus.in_pred_taken);
        new_c.redirect_pc = new_c.taken ? (bus.in_pc + bus.in_imm)
                                        : (bus.in_pc + XLEN'(4));
    end

    // Handshake qualifiers; ready depends only on the registered state.
    assign in_ready_c = (state_q != ST_FULL);
    assign accept_c   = bus.in_valid && in_ready_c && !bus.flush;
    assign pop_c      = bus.out_ready && (state_q != ST_EMPTY);

    // Buffer state register and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next-state logic of the skid buffer; flush dominates accept and pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        head_d  = new_c;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept_c, pop_c})
                        2'b10: begin
                            tail_d  = new_c;
                            state_d = ST_FULL;
                        end
                        2'b01:   state_d = ST_EMPTY;
                        2'b11:   head_d  = new_c;
                        default: state_d = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (pop_c) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Resolution outputs come straight from the head register.
    assign bus.in_ready        = in_ready_c;
    assign bus.out_valid       = (state_q != ST_EMPTY);
    assign bus.out_taken       = head_q.taken;
    assign bus.out_mispredict  = head_q.mispredict;
    assign bus.out_illegal     = head_q.illegal;
    assign bus.out_redirect_pc = head_q.redirect_pc;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CNT_W-1:0] stat_branches_q;
    logic [CNT_W-1:0] stat_taken_q;
    logic [CNT_W-1:0] stat_mispredicts_q;

    // Count accepted conditional branches, taken ones and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_taken_q       <= '0;
            stat_mispredicts_q <= '0;
        end else if (accept_c && bus.in_branch) begin
            stat_branches_q <= stat_branches_q + CNT_W'(1);
            if (new_c.taken) begin
                stat_taken_q <= stat_taken_q + CNT_W'(1);
            end
            if (new_c.mispredict) begin
                stat_mispredicts_q <= stat_mispredicts_q + CNT_W'(1);
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_taken       = stat_taken_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed corner cases plus random traffic.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(32)) bif ();

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_b, stat_t, stat_m;
`endif

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_branches    (stat_b),
        .stat_taken       (stat_t),
        .stat_mispredicts (stat_m)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   m_br = 0, m_tk = 0, m_mp = 0;
    bit   stalled = 0;
    exp_t snap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on widened operands.
    function automatic exp_t model(bit br, bit [2:0] code, bit [31:0] a, bit [31:0] b,
                                   bit [31:0] pc, bit [31:0] imm, bit pred);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint nxt;
        bit     cond;
        case (code)
            3'd0:    cond = (ua == ub);
            3'd1:    cond = (ua != ub);
            3'd2:    cond = (sa < sb);
            3'd3:    cond = (sa >= sb);
            3'd4:    cond = (ua < ub);
            3'd5:    cond = (ua >= ub);
            default: cond = 0;
        endcase
        e.ill   = br && (code >= 3'd6);
        e.taken = br && cond && (code <= 3'd5);
        e.mis   = br && (e.taken != pred);
        nxt     = e.taken ? (longint'({32'd0, pc}) + longint'({32'd0, imm}))
                          : (longint'({32'd0, pc}) + 64'sd4);
        nxt     = nxt % 64'sh1_0000_0000;
        e.pc    = nxt[31:0];
        return e;
    endfunction

    // Issue side of the scoreboard: record the expected result of every accepted request.
    always @(negedge clk) begin
        if (rst_n && bif.in_valid && bif.in_ready && !bif.flush) begin
            exp_t e;
            e = model(bif.in_branch, bif.in_comp_code, bif.in_rs1, bif.in_rs2,
                      bif.in_pc, bif.in_imm, bif.in_pred_taken);
            exp_q.push_back(e);
            if (bif.in_branch) begin
                m_br++;
                if (e.taken) m_tk++;
                if (e.mis) m_mp++;
            end
        end
    end

    // Monitor side: compare every popped resolution and check stalled outputs hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else if (bif.flush) begin
            exp_q.delete();
            stalled = 0;
        end else begin
            exp_t act;
            act = '{bif.out_taken, bif.out_mispredict, bif.out_illegal, bif.out_redirect_pc};
            if (stalled) chk("stall_hold", 64'(act), 64'(snap));
            stalled = 0;
            if (bif.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(1), 64'(0));
                end else if (bif.out_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resolution", 64'(act), 64'(e));
                end else begin
                    snap    = act;
                    stalled = 1;
                end
            end
        end
    end

    task automatic set_req(bit br, bit [2:0] code, bit [31:0] a, bit [31:0] b,
                           bit [31:0] pc, bit [31:0] imm, bit pred);
        bif.in_branch     = br;
        bif.in_comp_code  = code;
        bif.in_rs1        = a;
        bif.in_rs2        = b;
        bif.in_pc         = pc;
        bif.in_imm        = imm;
        bif.in_pred_taken = pred;
    endtask

    // Offer one request and hold it until accepted; returns just after the accepting edge.
    task automatic send(bit br, bit [2:0] code, bit [31:0] a, bit [31:0] b,
                        bit [31:0] pc, bit [31:0] imm, bit pred);
        int n = 0;
        set_req(br, code, a, b, pc, imm, pred);
        bif.in_valid = 1'b1;
        @(negedge clk);
        while (!bif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic check_stats(string tag);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk({tag, "_stat_branches"}, 64'(stat_b), 64'(m_br));
        chk({tag, "_stat_taken"}, 64'(stat_t), 64'(m_tk));
        chk({tag, "_stat_mispredicts"}, 64'(stat_m), 64'(m_mp));
`else
        total += 0;
`endif
    endtask

    function automatic bit [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        bit [5:0]  tk_tab;
        bit [31:0] a, b;
        bif.flush     = 1'b0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(bif.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bif.in_ready), 64'(1));
        chk("rst_out_taken", 64'(bif.out_taken), 64'(0));
        chk("rst_redirect", 64'(bif.out_redirect_pc), 64'(0));
        check_stats("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Compare coverage with -1 vs 1; expected taken per code is 0,1,1,0,0,1
        tk_tab = 6'b100110;
        bif.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            send(1, 3'(c), 32'hFFFF_FFFF, 32'h1, 32'h0000_1000, 32'h40, 0);
            @(negedge clk);
            chk("cov_latency", 64'(bif.out_valid), 64'(1));
            chk("cov_taken", 64'(bif.out_taken), 64'(tk_tab[c]));
            chk("cov_redirect", 64'(bif.out_redirect_pc),
                64'(tk_tab[c] ? 32'h0000_1040 : 32'h0000_1004));
            @(posedge clk);
            #1;
        end

        // PC wrap in both directions
        send(1, 3'd1, 32'h5, 32'h6, 32'hFFFF_FFFC, 32'h8, 0);
        @(negedge clk);
        chk("wrap_taken", 64'(bif.out_redirect_pc), 64'h4);
        @(posedge clk);
        #1;
        send(1, 3'd1, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 0);
        @(negedge clk);
        chk("wrap_not_taken", 64'(bif.out_redirect_pc), 64'h0);
        @(posedge clk);
        #1;

        // Reserved code and non-branch
        send(1, 3'd6, 32'h1, 32'h1, 32'h200, 32'h10, 1);
        @(negedge clk);
        chk("reserved_illegal", 64'(bif.out_illegal), 64'(1));
        chk("reserved_taken", 64'(bif.out_taken), 64'(0));
        @(posedge clk);
        #1;
        send(0, 3'd0, 32'h1, 32'h1, 32'h300, 32'h10, 1);
        @(negedge clk);
        chk("nonbranch_mispredict", 64'(bif.out_mispredict), 64'(0));
        chk("nonbranch_illegal", 64'(bif.out_illegal), 64'(0));
        @(posedge clk);
        #1;
        check_stats("directed");

        // Backpressure: two accepted, third refused, then release in order
        bif.out_ready = 1'b0;
        send(1, 3'd0, 32'h7, 32'h7, 32'h400, 32'h20, 0);
        send(1, 3'd2, 32'h7, 32'h3, 32'h500, 32'h20, 1);
        set_req(1, 3'd4, 32'h1, 32'h9, 32'h600, 32'h20, 0);
        bif.in_valid = 1'b1;
        @(negedge clk);
        chk("bp_full_ready", 64'(bif.in_ready), 64'(0));
        @(posedge clk);
        #1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_only_ready", 64'(bif.in_ready), 64'(0));
        for (int k = 0; k < 3; k++) begin
            bit acc;
            if (k > 0) @(negedge clk);
            chk("bp_drain_valid", 64'(bif.out_valid), 64'(1));
            acc = bif.in_ready && bif.in_valid;
            @(posedge clk);
            #1;
            if (acc) bif.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_drained", 64'(bif.out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Flush with two entries held and a request offered
        bif.out_ready = 1'b0;
        send(1, 3'd1, 32'h1, 32'h2, 32'h700, 32'h8, 0);
        send(1, 3'd1, 32'h1, 32'h2, 32'h800, 32'h8, 0);
        set_req(1, 3'd1, 32'h1, 32'h2, 32'h900, 32'h8, 0);
        bif.in_valid = 1'b1;
        bif.flush    = 1'b1;
        @(posedge clk);
        #1;
        bif.flush    = 1'b0;
        bif.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_empty", 64'(bif.out_valid), 64'(0));
        chk("flush_full_ready", 64'(bif.in_ready), 64'(1));
        check_stats("flush_full");
        @(posedge clk);
        #1;

        // Flush with one entry held while a request would have been accepted
        send(1, 3'd5, 32'h9, 32'h2, 32'hA00, 32'h8, 0);
        set_req(1, 3'd5, 32'h9, 32'h2, 32'hB00, 32'h8, 0);
        bif.in_valid = 1'b1;
        bif.flush    = 1'b1;
        @(posedge clk);
        #1;
        bif.flush    = 1'b0;
        bif.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_one_empty", 64'(bif.out_valid), 64'(0));
        check_stats("flush_one");
        @(posedge clk);
        #1;

        // Random traffic with random backpressure and occasional flush
        repeat (500) begin
            a = pick_op();
            b = ($urandom_range(0, 3) == 0) ? a : pick_op();
            set_req(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), a, b,
                    32'($urandom()) & 32'hFFFF_FFFC, 32'($urandom()) & 32'hFFFF_FFFE,
                    1'($urandom_range(0, 1)));
            bif.in_valid  = ($urandom_range(0, 3) != 0);
            bif.out_ready = ($urandom_range(0, 3) != 0);
            bif.flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            #1;
        end
        bif.in_valid  = 1'b0;
        bif.flush     = 1'b0;
        bif.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("random_drained", 64'(exp_q.size()), 64'(0));
        check_stats("random");
        @(posedge clk);
        #1;

        // Asynchronous reset while the buffer is full
        bif.out_ready = 1'b0;
        send(1, 3'd1, 32'h1, 32'h2, 32'hC00, 32'h8, 1);
        send(1, 3'd0, 32'h1, 32'h2, 32'hD00, 32'h8, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bif.out_valid), 64'(0));
        chk("midrst_in_ready", 64'(bif.in_ready), 64'(1));
        exp_q.delete();
        m_br = 0;
        m_tk = 0;
        m_mp = 0;
        stalled = 0;
        check_stats("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", 64'(bif.out_valid), 64'(0));
        @(posedge clk);
        #1;
        bif.out_ready = 1'b1;
        send(1, 3'd3, 32'h5, 32'h5, 32'hE00, 32'h30, 0);
        @(negedge clk);
        chk("postrst_resume", 64'(bif.out_redirect_pc), 64'hE30);
        @(posedge clk);
        #1;
        check_stats("postrst");
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage consumer of the 3-bit comparison code produced by the branch condition decoder. Accepts one branch/non-branch instruction per cycle over a valid/ready handshake, evaluates the comparison on the two register operands, computes the target, checks the fetch-stage prediction and returns a registered resolution through a 2-entry skid buffer. It sits between operand read and the fetch redirect path.

## Interface
- XLEN, 32, operand, PC and immediate width
- CNT_W, 32, width of statistics counters (used only with the statistics macro)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_branch  in  1  instruction is a conditional branch (B-type)
- in_comp_code  in  3  0 ==, 1 !=, 2 < signed, 3 >= signed, 4 < unsigned, 5 >= unsigned, 6–7 reserved
- in_rs1, in_rs2  in  XLEN  operands
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended B-immediate
- in_pred_taken  in  1  fetch-stage prediction
- out_valid  out  1  resolution valid
- out_ready  in  1  consumer accepts resolution
- out_taken  out  1  branch taken
- out_mispredict  out  1  out_taken differs from prediction
- out_redirect_pc  out  XLEN  correct next PC
- out_illegal  out  1  in_branch with reserved code
- stat_branches, stat_taken, stat_mispredicts  out  CNT_W  counters (macro-only)

## Operation
- Accept when in_valid && in_ready; evaluation uses request fields in the accept cycle and the result is written into the buffer.
- cond: per in_comp_code; signed compares use two's-complement XLEN, unsigned compares are plain magnitude.
- taken = in_branch && cond && code ≤ 5; reserved code with in_branch: taken=0, illegal=1.
- in_branch=0: taken=0, illegal=0, comp_code ignored.
- redirect_pc = taken ? in_pc + in_imm : in_pc + 4; both sums are mod 2^XLEN (wrap, no carry-out).
- mispredict = taken ^ in_pred_taken, forced 0 when in_branch=0.
- Buffer states: EMPTY, ONE, FULL (two entries, FIFO order). Output shows the head entry.
  - EMPTY: accept → ONE.
  - ONE: accept without pop → FULL; pop without accept → EMPTY; both → ONE, new entry becomes head next cycle.
  - FULL: pop → ONE; no accept possible.
- in_ready = state != FULL (registered-state function only; no combinational path from out_ready).
- flush: next state EMPTY, request in the same cycle is dropped, no counter updates for it; flush wins over accept and pop.
- Reset: state EMPTY, all outputs 0, counters 0.

## Timing
- Latency: accept at cycle N → out_valid at N+1 (from EMPTY or when head is popped at N).
- Throughput 1/cycle with out_ready held high.
- out_* fields stable while out_valid && !out_ready.
- out_valid never depends combinationally on in_valid.
- Reset asserted mid-operation clears contents immediately, no partial results after deassertion.
- Boundary: FULL with simultaneous pop and in_valid → pop only; in_ready rises the following cycle.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: stat_* ports present; on each accepted non-flushed request with in_branch=1, stat_branches++; additionally stat_taken++ if taken, stat_mispredicts++ if mispredict; counters wrap at 2^CNT_W.
- Undefined: stat_* ports and counters absent; all other behaviour identical.

## Test plan
- Reset: rst_n low mid-stream with FULL buffer → out_valid=0, in_ready=1, counters 0 immediately.
- Compare coverage: rs1=0xFFFFFFFF, rs2=1, codes 0–5, branch=1, pred=0 → taken 0,1,1,0,0,1; redirect = pc+imm when taken, else pc+4.
- Wrap: pc=0xFFFFFFFC, code 1, rs1≠rs2, imm=8 → redirect 0x00000004; non-taken variant → 0x00000000.
- Reserved/non-branch: code 6, branch=1 → taken=0, illegal=1; branch=0, pred=1 → mispredict=0.
- Backpressure: out_ready=0 for 3 cycles, 3 requests offered → two accepted, in_ready=0 on third, outputs stable; release → results in order, one per cycle.
- Flush + stats: two entries held, flush with simultaneous in_valid → EMPTY next cycle, dropped request absent, stat_branches unchanged by flushed request (macro on).
